// File: rtl/password_sequencer.sv
// -----------------------------------------------------------------------------
// password_sequencer
//
// Builds a DIGITS-long decimal password by driving an external 8-bit LFSR
// password generator once per digit (reset, load, settle, capture), reducing
// each captured byte modulo 10 by repeated subtraction. Once the password is
// complete it checks keypad entries against it, counts wrong full entries and
// ends in DEFUSED (correct entry) or BOOM (MAX_TRIES wrong entries).
//
// Parameters
//   DIGITS      password length, 1..8
//   MAX_TRIES   wrong full entries allowed before boom, 1..15
//   SETTLE_CYC  cycles the generator runs after load before capture, >= 1
//
// Optional feature
//   PWD_DEBUG_EN  when defined, pwd_debug exposes the stored digits; when
//                 undefined the port is tied to zero.
//
// Ports
//   clk, rst_n     system clock, asynchronous active-low reset
//   start          one-cycle pulse; starts generation from IDLE/DEFUSED/BOOM
//   seed_in        base seed, sampled on accepted start
//   entropy        entropy word, sampled on accepted start
//   gen_rst_n      registered reset to the generator
//   gen_load       registered load strobe to the generator
//   gen_seed       seed to the generator (never 8'h00)
//   gen_random     random input to the generator
//   gen_rand_num   generator output
//   key_valid      one-cycle strobe qualifying key_digit
//   key_digit      entered digit, 0..9 (anything larger never matches)
//   key_clear      discards the partial entry; wins over key_valid
//   busy           high while a password is being generated
//   armed          high while waiting for / checking an entry
//   defused        high after a correct entry
//   boom           high after the last allowed wrong entry
//   tries_left     remaining wrong entries allowed
//   pwd_debug      stored digits, digit i in bits [4i+3:4i]
// -----------------------------------------------------------------------------
module password_sequencer #(
  parameter int DIGITS     = 4,
  parameter int MAX_TRIES  = 3,
  parameter int SETTLE_CYC = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [7:0]  seed_in,
  input  logic [4:0]  entropy,
  output logic        gen_rst_n,
  output logic        gen_load,
  output logic [7:0]  gen_seed,
  output logic [4:0]  gen_random,
  input  logic [7:0]  gen_rand_num,
  input  logic        key_valid,
  input  logic [3:0]  key_digit,
  input  logic        key_clear,
  output logic        busy,
  output logic        armed,
  output logic        defused,
  output logic        boom,
  output logic [3:0]  tries_left,
  output logic [31:0] pwd_debug
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_GRST,
    S_LOAD,
    S_SETTLE,
    S_MOD,
    S_NEXT,
    S_ARMED,
    S_CHECK,
    S_DEFUSED,
    S_BOOM
  } state_t;

  // Settle counter only needs to reach SETTLE_CYC-1.
  localparam int CW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

  localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYC - 1);
  localparam logic [2:0]    LAST_IDX    = 3'(DIGITS - 1);
  localparam logic [3:0]    LAST_E      = 4'(DIGITS - 1);
  localparam logic [3:0]    TRIES_INIT  = 4'(MAX_TRIES);

  state_t          r_state;
  logic [7:0]      r_seed_q;
  logic [4:0]      r_entropy_q;
  logic [2:0]      r_idx;       // digit being generated
  logic [CW-1:0]   r_cnt;       // settle cycle counter
  logic [7:0]      r_v;         // captured byte, reduced in place
  logic [31:0]     r_digits;    // stored digits, 4 bits each
  logic [3:0]      r_e;         // entry index
  logic            r_m;         // mismatch seen in current entry

  state_t          w_state_nxt;
  logic [7:0]      w_seed_raw;
  logic [7:0]      w_seed_calc;
  logic [4:0]      w_rand_calc;
  logic [3:0]      w_digit_e;
  logic            w_key_take;

  // Generator inputs for the current digit. A zero seed would lock the LFSR
  // in its all-zero state, so it is replaced by a fixed non-zero pattern.
  assign w_seed_raw  = r_seed_q ^ {r_idx, 5'b0_0000};
  assign w_seed_calc = (w_seed_raw == 8'h00) ? 8'hA5 : w_seed_raw;
  assign w_rand_calc = r_entropy_q + {2'b00, r_idx};

  // Digit expected at the current entry position. Stored digits are always
  // 0..9, so a key_digit above 9 can never compare equal.
  assign w_digit_e  = r_digits[{r_e[2:0], 2'b00} +: 4];

  // A simultaneous clear drops the key.
  assign w_key_take = key_valid && !key_clear;

  // Next-state decode; the register block below derives every output from
  // w_state_nxt so outputs change in the same cycle as the state.
  always_comb begin
    // NOTE: default assignment first so no path leaves w_state_nxt unassigned
    // (which would infer a latch).
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE, S_DEFUSED, S_BOOM: if (start) w_state_nxt = S_GRST;
      S_GRST:   w_state_nxt = S_LOAD;
      S_LOAD:   w_state_nxt = S_SETTLE;
      S_SETTLE: if (r_cnt == SETTLE_LAST) w_state_nxt = S_MOD;
      S_MOD:    if (r_v < 8'd10) w_state_nxt = S_NEXT;
      S_NEXT:   w_state_nxt = (r_idx == LAST_IDX) ? S_ARMED : S_GRST;
      S_ARMED:  if (w_key_take && (r_e == LAST_E)) w_state_nxt = S_CHECK;
      S_CHECK: begin
        if (!r_m)                   w_state_nxt = S_DEFUSED;
        else if (tries_left > 4'd1) w_state_nxt = S_ARMED;
        else                        w_state_nxt = S_BOOM;
      end
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // NOTE: all state is updated with non-blocking assignments so every
  // register samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_seed_q    <= '0;
      r_entropy_q <= '0;
      r_idx       <= '0;
      r_cnt       <= '0;
      r_v         <= '0;
      // NOTE: the digit store is a plain register (not a RAM), so it is reset
      // along with everything else; pwd_debug must read zero out of reset.
      r_digits    <= '0;
      r_e         <= '0;
      r_m         <= 1'b0;
      gen_rst_n   <= 1'b0;
      gen_load    <= 1'b0;
      gen_seed    <= '0;
      gen_random  <= '0;
      busy        <= 1'b0;
      armed       <= 1'b0;
      defused     <= 1'b0;
      boom        <= 1'b0;
      tries_left  <= '0;
    end else begin
      r_state   <= w_state_nxt;

      // Registered outputs decoded from the state being entered.
      gen_rst_n <= (w_state_nxt != S_GRST);
      gen_load  <= (w_state_nxt == S_LOAD);
      busy      <= (w_state_nxt inside {S_GRST, S_LOAD, S_SETTLE, S_MOD, S_NEXT});
      armed     <= (w_state_nxt inside {S_ARMED, S_CHECK});
      defused   <= (w_state_nxt == S_DEFUSED);
      boom      <= (w_state_nxt == S_BOOM);

      case (r_state)
        S_IDLE, S_DEFUSED, S_BOOM: begin
          if (start) begin
            r_seed_q    <= seed_in;
            r_entropy_q <= entropy;
            r_idx       <= '0;
            tries_left  <= TRIES_INIT;
            r_digits    <= '0;
          end
        end

        S_GRST: begin
          // Seed and random are set on entry to LOAD and then held untouched
          // through SETTLE.
          gen_seed   <= w_seed_calc;
          gen_random <= w_rand_calc;
        end

        S_LOAD: r_cnt <= '0;

        S_SETTLE: begin
          r_cnt <= r_cnt + CW'(1);
          if (r_cnt == SETTLE_LAST) r_v <= gen_rand_num;
        end

        S_MOD: begin
          // Modulo 10 by repeated subtraction: at most 25 subtractions for 255.
          if (r_v >= 8'd10) r_v <= r_v - 8'd10;
          else              r_digits[{r_idx, 2'b00} +: 4] <= r_v[3:0];
        end

        S_NEXT: begin
          if (r_idx == LAST_IDX) begin
            r_e <= '0;
            r_m <= 1'b0;
          end else begin
            r_idx <= r_idx + 3'd1;
          end
        end

        S_ARMED: begin
          if (key_clear) begin
            r_e <= '0;
            r_m <= 1'b0;
          end else if (key_valid) begin
            r_m <= r_m | (key_digit != w_digit_e);
            r_e <= r_e + 4'd1;
          end
        end

        S_CHECK: begin
          if (r_m) begin
            if (tries_left > 4'd1) begin
              tries_left <= tries_left - 4'd1;
              r_e        <= '0;
              r_m        <= 1'b0;
            end else begin
              tries_left <= '0;
            end
          end
        end

        default: ;
      endcase
    end
  end

`ifdef PWD_DEBUG_EN
  assign pwd_debug = r_digits;
`else
  assign pwd_debug = 32'h0000_0000;
`endif

endmodule

// File: tb/tb_password_sequencer.sv
// -----------------------------------------------------------------------------
// tb_password_sequencer
//
// Self-checking bench for password_sequencer. A behavioural 8-bit LFSR stands
// in for the password generator. Expected generator loads (seed/random) are
// queued when a start is driven and compared as gen_load pulses appear;
// expected entry outcomes are queued when the last key of an entry is driven
// and compared when the DUT resolves the entry.
// -----------------------------------------------------------------------------
module tb_password_sequencer;

  localparam int DIGITS     = 4;
  localparam int MAX_TRIES  = 3;
  localparam int SETTLE_CYC = 32;
  localparam int ARM_BUDGET = DIGITS * (29 + SETTLE_CYC);

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [7:0]  seed_in;
  logic [4:0]  entropy;
  logic        gen_rst_n;
  logic        gen_load;
  logic [7:0]  gen_seed;
  logic [4:0]  gen_random;
  logic [7:0]  gen_rand_num;
  logic        key_valid;
  logic [3:0]  key_digit;
  logic        key_clear;
  logic        busy;
  logic        armed;
  logic        defused;
  logic        boom;
  logic [3:0]  tries_left;
  logic [31:0] pwd_debug;

  password_sequencer #(
    .DIGITS     (DIGITS),
    .MAX_TRIES  (MAX_TRIES),
    .SETTLE_CYC (SETTLE_CYC)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .seed_in      (seed_in),
    .entropy      (entropy),
    .gen_rst_n    (gen_rst_n),
    .gen_load     (gen_load),
    .gen_seed     (gen_seed),
    .gen_random   (gen_random),
    .gen_rand_num (gen_rand_num),
    .key_valid    (key_valid),
    .key_digit    (key_digit),
    .key_clear    (key_clear),
    .busy         (busy),
    .armed        (armed),
    .defused      (defused),
    .boom         (boom),
    .tries_left   (tries_left),
    .pwd_debug    (pwd_debug)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Generator model: cleared by gen_rst_n, loaded with gen_seed, then steps a
  // maximal-length Fibonacci LFSR (taps 8,6,5,4) once per clock. The output
  // mixes in gen_random.
  // ---------------------------------------------------------------------------
  function automatic logic [7:0] lfsr_step(input logic [7:0] l);
    return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
  endfunction

  logic [7:0] gen_lfsr;
  always @(posedge clk or negedge gen_rst_n) begin
    if (!gen_rst_n)    gen_lfsr <= 8'h00;
    else if (gen_load) gen_lfsr <= gen_seed;
    else               gen_lfsr <= lfsr_step(gen_lfsr);
  end
  assign gen_rand_num = gen_lfsr ^ {3'b000, gen_random};

  // Captured one cycle before the end of SETTLE: SETTLE_CYC-1 steps after load.
  function automatic logic [3:0] ref_digit(input logic [7:0] s, input logic [4:0] r);
    logic [7:0] l;
    l = s;
    for (int k = 0; k < SETTLE_CYC - 1; k++) l = lfsr_step(l);
    l = l ^ {3'b000, r};
    return 4'(l % 8'd10);
  endfunction

  // ---------------------------------------------------------------------------
  // Checking
  // ---------------------------------------------------------------------------
  int n_checks = 0;
  int n_fails  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Scoreboards
  // ---------------------------------------------------------------------------
  typedef struct packed {
    logic [7:0] seed;
    logic [4:0] rnd;
  } load_t;

  typedef struct packed {
    logic       armed;
    logic       defused;
    logic       boom;
    logic [3:0] tries;
  } outcome_t;

  load_t    sb_load[$];
  outcome_t sb_out[$];
  logic [3:0] exp_dig [DIGITS];

  // Every gen_load pulse must match the next queued seed/random pair.
  always @(negedge clk) begin
    if (rst_n && gen_load) begin
      if (sb_load.size() == 0) begin
        check("load_unexpected", 32'(sb_load.size()), 32'd1);
      end else begin
        load_t e;
        e = sb_load.pop_front();
        check("gen_seed",   32'(gen_seed),   32'(e.seed));
        check("gen_random", 32'(gen_random), 32'(e.rnd));
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers (all driving happens at negedges)
  // ---------------------------------------------------------------------------
  task automatic pulse_start(input logic [7:0] s, input logic [4:0] ent);
    seed_in = s;
    entropy = ent;
    start   = 1'b1;
    @(negedge clk);
    start   = 1'b0;
  endtask

  // Queue the expected generator loads and compute the reference digits.
  task automatic expect_run(input logic [7:0] s, input logic [4:0] ent);
    for (int i = 0; i < DIGITS; i++) begin
      load_t e;
      logic [2:0] ii;
      ii = 3'(i);
      e.seed = s ^ {ii, 5'b0_0000};
      if (e.seed == 8'h00) e.seed = 8'hA5;
      e.rnd = ent + 5'(i);
      sb_load.push_back(e);
      exp_dig[i] = ref_digit(e.seed, e.rnd);
    end
  endtask

  task automatic wait_armed(input string tag, inout int n);
    while (!armed && n < ARM_BUDGET) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_armed"},   32'(armed),          32'd1);
    check({tag, "_busy"},    32'(busy),           32'd0);
    check({tag, "_tries"},   32'(tries_left),     32'(MAX_TRIES));
    check({tag, "_sb_load"}, 32'(sb_load.size()), 32'd0);
  endtask

  task automatic check_digits(input string tag);
`ifdef PWD_DEBUG_EN
    for (int i = 0; i < 8; i++) begin
      logic [3:0] d;
      d = pwd_debug[4*i +: 4];
      if (i < DIGITS) begin
        check({tag, "_digit"},   32'(d), 32'(exp_dig[i]));
        check({tag, "_dig_le9"}, 32'(d <= 4'd9), 32'd1);
      end else begin
        check({tag, "_unused"},  32'(d), 32'd0);
      end
    end
`else
    check({tag, "_pwd_dbg_off"}, pwd_debug, 32'd0);
`endif
  endtask

  task automatic send_key(input logic [3:0] d, input logic clr);
    key_valid = 1'b1;
    key_digit = d;
    key_clear = clr;
    @(negedge clk);
    key_valid = 1'b0;
    key_clear = 1'b0;
  endtask

  function automatic logic [15:0] correct_code();
    return {exp_dig[3], exp_dig[2], exp_dig[1], exp_dig[0]};
  endfunction

  // Enter a full code, queue the expected outcome and compare it two cycles
  // after the last key strobe (and confirm nothing resolves one cycle early).
  task automatic enter_code(input string tag, input logic [15:0] code, input outcome_t exp);
    for (int i = 0; i < DIGITS; i++) begin
      if (i == DIGITS - 1) sb_out.push_back(exp);
      send_key(code[4*i +: 4], 1'b0);
    end
    check({tag, "_early_def"},  32'(defused), 32'd0);
    check({tag, "_early_boom"}, 32'(boom),    32'd0);
    @(negedge clk);
    begin
      outcome_t e;
      e = sb_out.pop_front();
      check({tag, "_armed"},   32'(armed),      32'(e.armed));
      check({tag, "_defused"}, 32'(defused),    32'(e.defused));
      check({tag, "_boom"},    32'(boom),       32'(e.boom));
      check({tag, "_tries"},   32'(tries_left), 32'(e.tries));
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_gen_rst_n"},  32'(gen_rst_n),  32'd0);
    check({tag, "_gen_load"},   32'(gen_load),   32'd0);
    check({tag, "_gen_seed"},   32'(gen_seed),   32'd0);
    check({tag, "_gen_random"}, 32'(gen_random), 32'd0);
    check({tag, "_busy"},       32'(busy),       32'd0);
    check({tag, "_armed"},      32'(armed),      32'd0);
    check({tag, "_defused"},    32'(defused),    32'd0);
    check({tag, "_boom"},       32'(boom),       32'd0);
    check({tag, "_tries"},      32'(tries_left), 32'd0);
    check({tag, "_pwd_debug"},  pwd_debug,       32'd0);
  endtask

  task automatic wait_load(input string tag, inout int n);
    while (!gen_load && n < ARM_BUDGET) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_load_seen"}, 32'(gen_load), 32'd1);
  endtask

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  initial begin
    int n;
    logic [15:0] code;
    outcome_t    o;

    rst_n     = 1'b0;
    start     = 1'b0;
    seed_in   = 8'h00;
    entropy   = 5'd0;
    key_valid = 1'b0;
    key_digit = 4'd0;
    key_clear = 1'b0;

    // Power-on reset values, then gen_rst_n releases on the first clk.
    repeat (2) @(negedge clk);
    check_reset_outputs("por");
    rst_n = 1'b1;
    #1;
    check("por_gen_rst_hold", 32'(gen_rst_n), 32'd0);
    @(negedge clk);
    check("por_gen_rst_rel", 32'(gen_rst_n), 32'd1);

    // Run A: seed 5A, entropy 3; a start mid-SETTLE must be ignored.
    expect_run(8'h5A, 5'd3);
    pulse_start(8'h5A, 5'd3);
    n = 0;
    check("a_busy", 32'(busy), 32'd1);
    wait_load("a", n);
    repeat (5) begin @(negedge clk); n++; end
    pulse_start(8'hFF, 5'd17);
    n++;
    wait_armed("a", n);
    check_digits("a");

    // Correct entry.
    o = '{armed: 1'b0, defused: 1'b1, boom: 1'b0, tries: 4'd3};
    enter_code("ok", correct_code(), o);

    // Run B from DEFUSED: zero seed, entropy wraps 31 -> 0.
    expect_run(8'h00, 5'd31);
    pulse_start(8'h00, 5'd31);
    n = 0;
    wait_armed("b", n);
    check_digits("b");

    // Three wrong entries: first digit wrong, last digit wrong, out-of-range key.
    code = correct_code();
    code[3:0] = 4'((exp_dig[0] + 4'd1) % 4'd10);
    o = '{armed: 1'b1, defused: 1'b0, boom: 1'b0, tries: 4'd2};
    enter_code("bad1", code, o);
    code = correct_code();
    code[15:12] = 4'((exp_dig[3] + 4'd5) % 4'd10);
    o = '{armed: 1'b1, defused: 1'b0, boom: 1'b0, tries: 4'd1};
    enter_code("bad2", code, o);
    code = correct_code();
    code[7:4] = 4'hF;
    o = '{armed: 1'b0, defused: 1'b0, boom: 1'b1, tries: 4'd0};
    enter_code("bad3", code, o);

    // Keys in BOOM change nothing.
    send_key(exp_dig[0], 1'b0);
    @(negedge clk);
    check("boom_hold",       32'(boom),       32'd1);
    check("boom_hold_tries", 32'(tries_left), 32'd0);
    check("boom_hold_armed", 32'(armed),      32'd0);

    // Run C from BOOM: clear with a simultaneous key after two good keys.
    expect_run(8'hC3, 5'd9);
    pulse_start(8'hC3, 5'd9);
    n = 0;
    wait_armed("c", n);
    send_key(exp_dig[0], 1'b0);
    send_key(exp_dig[1], 1'b0);
    send_key(exp_dig[2], 1'b1);
    o = '{armed: 1'b0, defused: 1'b1, boom: 1'b0, tries: 4'd3};
    enter_code("clr", correct_code(), o);

    // Run D: asynchronous reset in the middle of SETTLE.
    expect_run(8'h5A, 5'd3);
    pulse_start(8'h5A, 5'd3);
    n = 0;
    wait_load("d", n);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("mid");
    sb_load.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("mid_gen_rst_hold", 32'(gen_rst_n), 32'd0);
    @(negedge clk);
    check("mid_gen_rst_rel", 32'(gen_rst_n), 32'd1);
    check("mid_idle_busy",   32'(busy),      32'd0);
    repeat (3) @(negedge clk);
    check("mid_idle_load",   32'(gen_load),  32'd0);

    $display("%0d/%0d checks passed", n_checks - n_fails, n_checks);
    $finish;
  end

  // Hard stop in case the sequence itself stalls.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/password_sequencer.md
# password_sequencer

Controller that sequences the 8-bit LFSR password generator to build a DIGITS-long decimal bomb password, then checks player key entry against it. For each digit it resets, seeds and runs the generator, then reduces the captured byte modulo 10. It also counts failed attempts and raises defused or boom. It sits between the game top level / keypad decoder and the generator instance, and owns the generator's reset, load, seed and random inputs.

## Interface
- DIGITS, 4, password length; legal range 1..8
- MAX_TRIES, 3, wrong full entries allowed before boom; legal range 1..15
- SETTLE_CYC, 32, cycles the generator runs after load before capture; must be ≥ 1
- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse; begins password generation (IDLE/DEFUSED/BOOM only)
- seed_in  in  8  base seed, sampled on accepted start
- entropy  in  5  entropy word, sampled on accepted start
- gen_rst_n  out  1  registered reset to the generator
- gen_load  out  1  registered load strobe to the generator
- gen_seed  out  8  seed to the generator
- gen_random  out  5  random input to the generator
- gen_rand_num  in  8  generator output
- key_valid  in  1  one-cycle strobe with key_digit
- key_digit  in  4  entered digit, 0..9
- key_clear  in  1  discards partial entry
- busy  out  1  high in GRST..NEXT
- armed  out  1  high in ARMED and CHECK
- defused  out  1  high in DEFUSED
- boom  out  1  high in BOOM
- tries_left  out  4  remaining attempts
- pwd_debug  out  32  stored digits, digit i in bits [4i+3:4i]

## Operation
- States: IDLE, GRST, LOAD, SETTLE, MOD, NEXT, ARMED, CHECK, DEFUSED, BOOM.
- Accepted start (IDLE/DEFUSED/BOOM) has these effects:
  - registers seed_in and entropy;
  - sets idx=0 and tries_left=MAX_TRIES;
  - clears the stored digits;
  - moves to GRST.
- start in any other state is ignored.
- GRST: gen_rst_n=0 for 1 cycle; then LOAD. This clears the generator's internal run counter.
- LOAD: gen_load=1 for 1 cycle; then SETTLE.
- Seed and random inputs:
  - gen_seed = seed_q ^ {idx[2:0],5'b0}. If that is 8'h00, drive 8'hA5, because a zero seed locks the LFSR.
  - gen_random = entropy_q + idx[4:0], mod 32.
  - Both are held stable from LOAD through SETTLE.
- SETTLE: counts SETTLE_CYC cycles. On the last cycle, capture v=gen_rand_num and go to MOD.
- MOD: each cycle, if v≥10 then v←v−10. Otherwise store v as digit[idx] and go to NEXT.
- NEXT: if idx==DIGITS−1, go to ARMED with entry index e=0 and mismatch flag m=0. Else idx++ and go to GRST.
- ARMED:
  - key_valid sets m |= (key_digit≠digit[e]) and e++.
  - When the DIGITSth key is accepted, go to CHECK.
  - key_clear sets e=0 and m=0.
  - key_clear with key_valid in the same cycle: clear wins and the key is dropped.
  - key_digit>9 counts as a mismatch.
- CHECK (1 cycle):
  - m=0: go to DEFUSED.
  - m=1 and tries_left>1: tries_left−1, e=0, m=0, back to ARMED.
  - m=1 and tries_left==1: tries_left=0, go to BOOM.
- DEFUSED/BOOM hold until the next start. key_valid is ignored there and everywhere outside ARMED.
- Unused pwd_debug bits (digits ≥ DIGITS) are 0.

## Timing
- Reset values: state IDLE, gen_rst_n=0, gen_load=0, gen_seed=0, gen_random=0, busy=0, armed=0, defused=0, boom=0, tries_left=0, pwd_debug=0, all digits 0.
- gen_rst_n goes to 1 on the first clk after reset release.
- All outputs are registered.
- Per-digit latency is 1 (GRST) + 1 (LOAD) + SETTLE_CYC + (⌊v/10⌋+1) (MOD) + 1 (NEXT) cycles. The maximum MOD time is 26 cycles, for v=255.
- Start to armed is at most DIGITS·(29+SETTLE_CYC) cycles; 244 with the defaults.
- The first key is accepted in the cycle after armed rises.
- defused or boom rises 2 cycles after the last key strobe: one cycle for the key, one for CHECK.
- Asynchronous reset mid-operation returns every output to its reset value immediately and drives the generator into reset.

## Configuration
- PWD_DEBUG_EN defined: pwd_debug carries the stored digits as described above.
- PWD_DEBUG_EN undefined: pwd_debug is tied to 0. The port still exists, so no netlist change is needed.
- All other behaviour is identical in both builds.

## Test plan
- Reset check: assert rst_n=0 mid-SETTLE. All outputs must return to their reset values, and gen_rst_n must stay 0 until the first clk after release.
- Generation, start with seed_in=8'h5A, entropy=5'd3 and PWD_DEBUG_EN defined. Required:
  - gen_seed sequence 5A, 7A, 1A, 3A;
  - gen_random sequence 3, 4, 5, 6;
  - armed within 244 cycles;
  - each pwd_debug digit equals the reference LFSR model mod 10 and is ≤9.
- Zero seed: seed_in=8'h00 gives gen_seed 8'hA5 for idx 0 and 8'h20 for idx 1.
- Correct entry: the stored 4 digits give defused=1 two cycles after the 4th key, with tries_left=3.
- Wrong entries: three wrong 4-digit entries step tries_left 3→2→1, and then boom=1 with tries_left=0. A later key_valid causes no change; start restarts generation.
- Clear and ignored inputs:
  - key_clear after 2 correct keys, with key_valid in the same cycle, leaves e=0. The following 4 correct keys give defused.
  - start pulsed during SETTLE is ignored; the idx sequence is unchanged.
